// File: rtl/btb_predictor.sv
// Direct-mapped branch target buffer: same-cycle fetch lookup per lane, execute-side
// update with first-mispredict detection and a registered mismatch/redirect report.
module btb_predictor #(
   parameter int WIDTH    = 2,
   parameter int ENTRIES  = 32,
   parameter int IDX_BITS = 5,
   parameter int TAG_BITS = 8
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic [WIDTH*32-1:0]   if_pc,
   output logic [WIDTH-1:0]      btb_hit,
   output logic [WIDTH-1:0]      btb_taken,
   output logic [WIDTH*32-1:0]   btb_target,
   input  logic [WIDTH-1:0]      ex_valid,
   input  logic [WIDTH*32-1:0]   ex_pc,
   input  logic [WIDTH-1:0]      ex_taken,
   input  logic [WIDTH*32-1:0]   ex_target,
   input  logic [WIDTH-1:0]      ex_pred_taken,
   input  logic [WIDTH*32-1:0]   ex_pred_target,
   output logic [WIDTH-1:0]      mismatch,
   output logic [31:0]           redirect_pc
);

   logic                valid_q  [ENTRIES];
   logic [TAG_BITS-1:0] tag_q    [ENTRIES];
   logic [31:0]         target_q [ENTRIES];
   logic [1:0]          cnt_q    [ENTRIES];

   logic [WIDTH-1:0]    mispred;
   logic [WIDTH-1:0]    survive;
   logic [WIDTH-1:0]    first_oh;
   logic [31:0]         redirect_next;

   logic [WIDTH-1:0]    upd_we;
   logic [IDX_BITS-1:0] upd_idx    [WIDTH];
   logic [TAG_BITS-1:0] upd_tag    [WIDTH];
   logic [31:0]         upd_target [WIDTH];
   logic [1:0]          upd_cnt    [WIDTH];

   logic unused_pc_bits;
   assign unused_pc_bits = ^{if_pc, ex_pc};

   always_comb begin
      btb_hit    = '0;
      btb_taken  = '0;
      btb_target = '0;
      for (int i = 0; i < WIDTH; i++) begin
         logic [IDX_BITS-1:0] idx;
         logic [TAG_BITS-1:0] tag;
         idx = if_pc[i*32+2 +: IDX_BITS];
         tag = if_pc[i*32+IDX_BITS+2 +: TAG_BITS];
         if (!reset && valid_q[idx] && tag_q[idx] == tag) begin
            btb_hit[i]             = 1'b1;
            btb_taken[i]           = cnt_q[idx][1];
            btb_target[i*32 +: 32] = target_q[idx];
         end
      end
   end

   // Lanes after the first mispredict are wrong-path; every lane's new entry is
   // built from pre-edge state so two lanes on one index do not chain.
   always_comb begin
      logic found;
      found         = 1'b0;
      mispred       = '0;
      survive       = '0;
      first_oh      = '0;
      redirect_next = redirect_pc;
      upd_we        = '0;
      for (int i = 0; i < WIDTH; i++) begin
         logic [IDX_BITS-1:0] idx;
         logic [TAG_BITS-1:0] tag;
         logic                hit;
         idx = ex_pc[i*32+2 +: IDX_BITS];
         tag = ex_pc[i*32+IDX_BITS+2 +: TAG_BITS];
         hit = valid_q[idx] && tag_q[idx] == tag;

         mispred[i] = ex_valid[i] &&
                      (ex_pred_taken[i] != ex_taken[i] ||
                       (ex_taken[i] && ex_pred_target[i*32 +: 32] != ex_target[i*32 +: 32]));
         survive[i] = ex_valid[i] && !found;
         if (mispred[i] && !found) begin
            found         = 1'b1;
            first_oh[i]   = 1'b1;
            redirect_next = ex_taken[i] ? ex_target[i*32 +: 32] : ex_pc[i*32 +: 32] + 32'd4;
         end

         upd_idx[i]    = idx;
         upd_tag[i]    = tag;
         upd_target[i] = target_q[idx];
         upd_cnt[i]    = cnt_q[idx];
         if (survive[i]) begin
            if (hit) begin
               upd_we[i] = 1'b1;
               if (ex_taken[i]) begin
                  upd_target[i] = ex_target[i*32 +: 32];
                  upd_cnt[i]    = (cnt_q[idx] == 2'b11) ? 2'b11 : cnt_q[idx] + 2'd1;
               end else begin
                  upd_cnt[i]    = (cnt_q[idx] == 2'b00) ? 2'b00 : cnt_q[idx] - 2'd1;
               end
            end else if (ex_taken[i]) begin
               upd_we[i]     = 1'b1;
               upd_target[i] = ex_target[i*32 +: 32];
               upd_cnt[i]    = 2'b10;
            end
         end
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int e = 0; e < ENTRIES; e++) begin
            valid_q[e]  <= 1'b0;
            tag_q[e]    <= '0;
            target_q[e] <= '0;
            cnt_q[e]    <= 2'b01;
         end
         mismatch    <= '0;
         redirect_pc <= '0;
      end else begin
         for (int i = 0; i < WIDTH; i++) begin
            if (upd_we[i]) begin
               valid_q[upd_idx[i]]  <= 1'b1;
               tag_q[upd_idx[i]]    <= upd_tag[i];
               target_q[upd_idx[i]] <= upd_target[i];
               cnt_q[upd_idx[i]]    <= upd_cnt[i];
            end
         end
         mismatch    <= first_oh;
         redirect_pc <= redirect_next;
      end
   end

endmodule

// File: tb/tb_btb_predictor.sv
// Table-driven bench for btb_predictor: lookup checked combinationally each cycle,
// registered mismatch/redirect checked through a scoreboard queue one edge later.
module tb_btb_predictor;

   logic          clock = 1'b0;
   logic          reset;
   logic [63:0]   if_pc;
   logic [1:0]    btb_hit, btb_taken;
   logic [63:0]   btb_target;
   logic [1:0]    ex_valid, ex_taken, ex_pred_taken;
   logic [63:0]   ex_pc, ex_target, ex_pred_target;
   logic [1:0]    mismatch;
   logic [31:0]   redirect_pc;

   int n_checks = 0;
   int n_fails  = 0;

   typedef struct {
      logic [31:0] if0, if1;
      logic [1:0]  exp_hit, exp_taken;
      logic [31:0] exp_t0, exp_t1;
      logic [1:0]  ex_v, ex_tk, ex_ptk;
      logic [31:0] ex_pc0, ex_pc1, ex_t0, ex_t1, ex_pt0, ex_pt1;
      logic [1:0]  exp_mm;
      logic [31:0] exp_rd;
   } vec_t;

   typedef struct {
      logic [1:0]  mm;
      logic [31:0] rd;
   } sb_t;

   sb_t  sb[$];
   vec_t vecs[12];

   btb_predictor #(.WIDTH(2), .ENTRIES(32), .IDX_BITS(5), .TAG_BITS(8)) dut (
      .clock(clock), .reset(reset), .if_pc(if_pc),
      .btb_hit(btb_hit), .btb_taken(btb_taken), .btb_target(btb_target),
      .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_taken(ex_taken), .ex_target(ex_target),
      .ex_pred_taken(ex_pred_taken), .ex_pred_target(ex_pred_target),
      .mismatch(mismatch), .redirect_pc(redirect_pc)
   );

   always #5 clock = ~clock;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fails++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic checkOutput(input int n, input vec_t v);
      sb_t e;
      check($sformatf("v%0d btb_hit", n),    {30'd0, btb_hit},     {30'd0, v.exp_hit});
      check($sformatf("v%0d btb_taken", n),  {30'd0, btb_taken},   {30'd0, v.exp_taken});
      check($sformatf("v%0d btb_target0", n), btb_target[31:0],    v.exp_t0);
      check($sformatf("v%0d btb_target1", n), btb_target[63:32],   v.exp_t1);
      sb.push_back('{v.exp_mm, v.exp_rd});
      @(posedge clock);
      #1;
      if (sb.size() == 0) begin
         check($sformatf("v%0d scoreboard empty", n), 32'd1, 32'd0);
      end else begin
         e = sb.pop_front();
         check($sformatf("v%0d mismatch", n), {30'd0, mismatch}, {30'd0, e.mm});
         check($sformatf("v%0d redirect_pc", n), redirect_pc, e.rd);
      end
   endtask

   task automatic applyStimulus(input vec_t v);
      @(negedge clock);
      if_pc          = {v.if1, v.if0};
      ex_valid       = v.ex_v;
      ex_taken       = v.ex_tk;
      ex_pred_taken  = v.ex_ptk;
      ex_pc          = {v.ex_pc1, v.ex_pc0};
      ex_target      = {v.ex_t1, v.ex_t0};
      ex_pred_target = {v.ex_pt1, v.ex_pt0};
      #1;
   endtask

   initial begin
      reset = 1'b1;
      if_pc = '0; ex_valid = '0; ex_taken = '0; ex_pred_taken = '0;
      ex_pc = '0; ex_target = '0; ex_pred_target = '0;

      //          if0     if1    hit    tkn    t0     t1     v      tk     ptk    pc0    pc1    t0     t1     pt0    pt1    mm     rd
      vecs[0]  = '{'h40,  'h44,  2'b00, 2'b00, 'h0,   'h0,   2'b00, 2'b00, 2'b00, 'h0,   'h0,   'h0,   'h0,   'h0,   'h0,   2'b00, 'h0};
      vecs[1]  = '{'h40,  'h44,  2'b00, 2'b00, 'h0,   'h0,   2'b01, 2'b01, 2'b00, 'h40,  'h0,   'h100, 'h0,   'h0,   'h0,   2'b01, 'h100};
      vecs[2]  = '{'h40,  'h44,  2'b01, 2'b01, 'h100, 'h0,   2'b01, 2'b00, 2'b01, 'h40,  'h0,   'h0,   'h0,   'h100, 'h0,   2'b01, 'h44};
      vecs[3]  = '{'h40,  'h44,  2'b01, 2'b00, 'h100, 'h0,   2'b01, 2'b00, 2'b01, 'h40,  'h0,   'h0,   'h0,   'h100, 'h0,   2'b01, 'h44};
      vecs[4]  = '{'h40,  'h44,  2'b01, 2'b00, 'h100, 'h0,   2'b11, 2'b10, 2'b01, 'h80,  'h84,  'h0,   'h200, 'h0,   'h0,   2'b01, 'h84};
      vecs[5]  = '{'h80,  'h84,  2'b00, 2'b00, 'h0,   'h0,   2'b11, 2'b11, 2'b11, 'h40,  'hC0,  'h300, 'h400, 'h300, 'h400, 2'b00, 'h84};
      vecs[6]  = '{'h40,  'hC0,  2'b10, 2'b10, 'h0,   'h400, 2'b00, 2'b00, 2'b01, 'h0,   'h0,   'h0,   'h0,   'h0,   'h0,   2'b00, 'h84};
      vecs[7]  = '{'h40,  'hC0,  2'b10, 2'b10, 'h0,   'h400, 2'b11, 2'b11, 2'b11, 'hC0,  'h200, 'h400, 'h500, 'h400, 'h504, 2'b10, 'h500};
      vecs[8]  = '{'h203, 'hC0,  2'b11, 2'b11, 'h500, 'h400, 2'b00, 2'b00, 2'b00, 'h0,   'h0,   'h0,   'h0,   'h0,   'h0,   2'b00, 'h500};
      vecs[9]  = '{'hC0,  'h44,  2'b01, 2'b01, 'h400, 'h0,   2'b01, 2'b01, 2'b01, 'hC0,  'h0,   'h400, 'h0,   'h400, 'h0,   2'b00, 'h500};
      vecs[10] = '{'hC0,  'h44,  2'b01, 2'b01, 'h400, 'h0,   2'b01, 2'b00, 2'b01, 'hC0,  'h0,   'h0,   'h0,   'h0,   'h0,   2'b01, 'hC4};
      vecs[11] = '{'hC0,  'h203, 2'b11, 2'b11, 'h400, 'h500, 2'b00, 2'b00, 2'b00, 'h0,   'h0,   'h0,   'h0,   'h0,   'h0,   2'b00, 'hC4};

      repeat (2) @(posedge clock);
      @(negedge clock);
      reset = 1'b0;

      for (int i = 0; i < 12; i++) begin
         applyStimulus(vecs[i]);
         checkOutput(i, vecs[i]);
      end

      // Reset lands between edges while a mispredicting update is being presented.
      @(negedge clock);
      if_pc = {32'h203, 32'hC0};
      ex_valid = 2'b01; ex_taken = 2'b01; ex_pred_taken = 2'b00;
      ex_pc = {32'h0, 32'h300}; ex_target = {32'h0, 32'h600}; ex_pred_target = '0;
      #2 reset = 1'b1;
      #1;
      check("async btb_hit",     {30'd0, btb_hit},   32'd0);
      check("async btb_taken",   {30'd0, btb_taken}, 32'd0);
      check("async btb_target0", btb_target[31:0],   32'd0);
      check("async btb_target1", btb_target[63:32],  32'd0);
      check("async mismatch",    {30'd0, mismatch},  32'd0);
      check("async redirect_pc", redirect_pc,        32'd0);
      @(posedge clock);
      #1;
      check("held reset mismatch", {30'd0, mismatch}, 32'd0);

      @(negedge clock);
      reset = 1'b0;
      if_pc = {32'h300, 32'hC0};
      #1;
      check("post-reset btb_hit", {30'd0, btb_hit}, 32'd0);
      @(posedge clock);
      #1;
      check("first edge mismatch",    {30'd0, mismatch}, 32'd1);
      check("first edge redirect_pc", redirect_pc,       32'h600);
      @(negedge clock);
      ex_valid = 2'b00;
      #1;
      check("first edge alloc hit",    {30'd0, btb_hit},  32'd2);
      check("first edge alloc target", btb_target[63:32], 32'h600);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

   initial begin
      #20000;
      $display("[TB] FAIL timeout: got running expected finished");
      $fatal(1, "[TB] timeout");
   end

endmodule
